// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the processor (P) and a DMA port (D).
// Fixed priority to P with a starvation override, plus a tagged read-return pipe.
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int READ_LAT   = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              p_req,
  input  logic              p_wr,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_stall,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_rvalid,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              memEn,
  output logic              memWrEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] memDataOut
);

  logic [3:0]          starve_cnt;
  logic                d_wins;
  logic [READ_LAT-1:0] pipe_v;
  logic [READ_LAT-1:0] pipe_id;

  // D takes the cycle when alone, or when it has waited long enough
  assign d_wins  = d_req & (~p_req | (starve_cnt >= 4'(STARVE_LIM)));
  assign d_gnt   = ~Reset & d_wins;
  assign p_gnt   = ~Reset & p_req & ~d_wins;
  assign p_stall = p_req & ~p_gnt;
  assign memEn   = p_gnt | d_gnt;

  always_comb begin
    memWrEn   = 1'b0;
    memAddr   = '0;
    memDataIn = '0;
    unique case (1'b1)
      p_gnt: begin
        memWrEn   = p_wr;
        memAddr   = p_addr;
        memDataIn = p_wdata;
      end
      d_gnt: begin
        memWrEn   = d_wr;
        memAddr   = d_addr;
        memDataIn = d_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (d_req & ~d_gnt) begin
      if (starve_cnt != 4'hF)
        starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Tag each read with its requester; the tag pops out with the memory data
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= memEn & ~memWrEn;
      pipe_id[0] <= d_gnt;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign p_rvalid = pipe_v[READ_LAT-1] & ~pipe_id[READ_LAT-1];
  assign d_rvalid = pipe_v[READ_LAT-1] & pipe_id[READ_LAT-1];
  assign p_rdata  = memDataOut;
  assign d_rdata  = memDataOut;

endmodule
